// File: rtl/minisys_pkg.sv
// rtl/minisys_pkg.sv - shared receiver state type and bit-timing helper for the minisys loader
package minisys_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clocks per UART bit, truncated
    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

    localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(23000000, 128000);

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer and bit timing
module uart_rx_byte
    import minisys_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 23000000,
    parameter int BAUD        = 128000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_stop_err,
    output logic       o_busy
);
    localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_d;
    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_stop_err;
    logic             w_half_tick;
    logic             w_full_tick;
    logic             w_fall;

    assign w_half_tick  = (r_cnt == CNT_W'(HALF - 1));
    assign w_full_tick  = (r_cnt == CNT_W'(CPB - 1));
    assign w_fall       = r_rx_d & ~r_sync2;
    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_stop_err   = r_stop_err;
    assign o_busy       = (r_state != IDLE);

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
        end
    end

    // Receiver state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start bit is re-checked at mid-bit so short glitches fall back to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_state_next = START;
            START:   if (w_half_tick) w_state_next = r_sync2 ? IDLE : DATA;
            DATA:    if (w_full_tick && (r_bit_idx == 3'd7)) w_state_next = STOP;
            STOP:    if (w_full_tick) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bit timer, LSB-first shifter and one-cycle result pulses after the stop sample
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
                START: begin
                    r_cnt <= w_half_tick ? '0 : r_cnt + CNT_W'(1);
                end
                DATA: begin
                    if (w_full_tick) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_full_tick) begin
                        r_cnt        <= '0;
                        r_byte_valid <= r_sync2;
                        r_stop_err   <= ~r_sync2;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART-to-instruction-memory program loader; LOADER_CHECKSUM_EN adds checksum output
module uart_prog_loader
    import minisys_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 23000000,
    parameter int BAUD        = 128000,
    parameter int ADDR_W      = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_mode,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   word_count,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_stop_err;
    logic              w_busy;
    logic              w_load_rise;
    logic              w_accept;
    logic              r_load_d;
    logic              r_cpu_rst;
    logic [1:0]        r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_frame_err;
    logic              r_overflow;

    uart_rx_byte #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) u_rx (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_rx         (uart_rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_stop_err   (w_stop_err),
        .o_busy       (w_busy)
    );

    assign w_load_rise = load_mode & ~r_load_d;
    assign w_accept    = w_byte_valid & load_mode & ~w_load_rise;

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign word_count = r_count;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign busy       = w_busy;

    // CPU stays in reset while downloading and until the last frame has fully arrived
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cpu_rst <= 1'b1;
            r_load_d  <= 1'b0;
        end else begin
            r_cpu_rst <= load_mode | w_busy;
            r_load_d  <= load_mode;
        end
    end

    // Byte packer, write strobe, address/count advance and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // A strobe already issued always completes, even if load_mode just fell
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_addr == {ADDR_W{1'b1}}) r_overflow <= 1'b1;
                if (r_count != DEPTH) r_count <= r_count + (ADDR_W + 1)'(1);
            end
            if (w_stop_err) r_frame_err <= 1'b1;
            if (w_load_rise) begin
                r_addr      <= '0;
                r_count     <= '0;
                r_idx       <= '0;
                r_frame_err <= 1'b0;
                r_overflow  <= 1'b0;
            end else if (!load_mode) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_wdata[{r_idx, 3'b000} +: 8] <= w_byte;
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) r_we <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    assign checksum = r_checksum;

    // Running modulo-256 sum of accepted bytes, restarted with each download
    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_load_rise) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + w_byte;
        end
    end
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;
    localparam int CLK_HZ = 2048000;
    localparam int BAUD   = 128000;
    localparam int CPB    = 16;
    localparam int AW     = 2;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          load_mode = 1'b0;
    logic          uart_rx   = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic [AW:0]   word_count;
    logic          frame_err;
    logic          overflow;
    logic          busy;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            we_cnt    = 0;
    int            b2b       = 0;
    logic          prev_we   = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;

    always #5 clock = ~clock;

    uart_prog_loader #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD),
        .ADDR_W      (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_mode  (load_mode),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .word_count (word_count),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Write-port monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (imem_we) begin
            if (prev_we) b2b++;
            we_cnt++;
            last_addr = imem_addr;
            last_data = imem_wdata;
        end
        prev_we = imem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
        tick(4);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    initial begin
        tick(3);
        chk("rst_we",      32'(imem_we),    32'd0);
        chk("rst_addr",    32'(imem_addr),  32'd0);
        chk("rst_wdata",   imem_wdata,      32'd0);
        chk("rst_count",   32'(word_count), 32'd0);
        chk("rst_ferr",    32'(frame_err),  32'd0);
        chk("rst_ovf",     32'(overflow),   32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst),    32'd1);
        reset = 1'b0;
        chk("cpu_rst_pre_release", 32'(cpu_rst), 32'd1);
        tick(1);
        chk("cpu_rst_release", 32'(cpu_rst), 32'd0);

        // First word
        load_mode = 1'b1;
        tick(1);
        chk("cpu_rst_load", 32'(cpu_rst), 32'd1);
        send_word(32'h12345678);
        chk("w1_we_cnt", 32'(we_cnt),     32'd1);
        chk("w1_addr",   32'(last_addr),  32'd0);
        chk("w1_data",   last_data,       32'h12345678);
        chk("w1_next",   32'(imem_addr),  32'd1);
        chk("w1_count",  32'(word_count), 32'd1);

        // Bad stop bit between good bytes
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b0);
        chk("ferr_set",    32'(frame_err), 32'd1);
        chk("ferr_no_we",  32'(we_cnt),    32'd1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        chk("w2_we_cnt", 32'(we_cnt),     32'd2);
        chk("w2_addr",   32'(last_addr),  32'd1);
        chk("w2_data",   last_data,       32'hDDCCBBAA);
        chk("w2_count",  32'(word_count), 32'd2);

        // Restart clears address, count and flags
        load_mode = 1'b0;
        tick(1);
        load_mode = 1'b1;
        tick(2);
        chk("rise_addr",  32'(imem_addr),  32'd0);
        chk("rise_count", 32'(word_count), 32'd0);
        chk("rise_ferr",  32'(frame_err),  32'd0);

        // Six bytes with load_mode dropped during the sixth
        send_word(32'h04030201);
        send_byte(8'h05, 1'b1);
        fork
            send_byte(8'h06, 1'b1);
            begin
                tick(40);
                load_mode = 1'b0;
                tick(1);
                chk("drop_busy",    32'(busy),    32'd1);
                chk("drop_cpu_rst", 32'(cpu_rst), 32'd1);
                for (int i = 0; i < 400 && busy; i++) tick(1);
                chk("drop_busy_clear", 32'(busy),    32'd0);
                chk("drop_cpu_hold",   32'(cpu_rst), 32'd1);
                tick(1);
                chk("drop_cpu_fall",   32'(cpu_rst), 32'd0);
            end
        join
        chk("drop_we_cnt", 32'(we_cnt),     32'd3);
        chk("drop_addr",   32'(last_addr),  32'd0);
        chk("drop_data",   last_data,       32'h04030201);
        chk("drop_next",   32'(imem_addr),  32'd1);
        chk("drop_count",  32'(word_count), 32'd1);

        // Reload and fill the 4-word memory past its end
        load_mode = 1'b1;
        tick(2);
        chk("reload_addr",  32'(imem_addr),  32'd0);
        chk("reload_count", 32'(word_count), 32'd0);
        send_word(32'hA4A3A2A1);
        chk("f1_addr", 32'(last_addr), 32'd0);
        chk("f1_data", last_data,      32'hA4A3A2A1);
        send_word(32'h11223344);
        send_word(32'hFF00FF00);
        chk("f3_ovf",   32'(overflow),   32'd0);
        chk("f3_count", 32'(word_count), 32'd3);
        send_word(32'hDEADBEEF);
        chk("f4_addr",  32'(last_addr),  32'd3);
        chk("f4_data",  last_data,       32'hDEADBEEF);
        chk("f4_ovf",   32'(overflow),   32'd1);
        chk("f4_wrap",  32'(imem_addr),  32'd0);
        chk("f4_count", 32'(word_count), 32'd4);
        send_word(32'hFE7F8001);
        chk("f5_addr",  32'(last_addr),  32'd0);
        chk("f5_data",  last_data,       32'hFE7F8001);
        chk("f5_count", 32'(word_count), 32'd4);
        chk("f5_next",  32'(imem_addr),  32'd1);
        chk("we_total", 32'(we_cnt),     32'd8);
        chk("no_b2b",   32'(b2b),        32'd0);

`ifdef LOADER_CHECKSUM_EN
        load_mode = 1'b0;
        tick(1);
        load_mode = 1'b1;
        tick(2);
        chk("csum_clear", 32'(checksum), 32'h00);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h02, 1'b1);
        chk("csum_sum", 32'(checksum), 32'h01);
`endif

        // One-cycle low glitch on the line
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(4);
        chk("glitch_busy", 32'(busy), 32'd1);
        tick(20);
        chk("glitch_idle",   32'(busy),   32'd0);
        chk("glitch_no_we",  32'(we_cnt), 32'd8);
`ifdef LOADER_CHECKSUM_EN
        chk("glitch_csum",   32'(checksum), 32'h01);
`else
        chk("glitch_count",  32'(word_count), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
